// File: rtl/merge_run_feeder.sv
// Producer side of the two-way merge: streams bytes from a FWFT source into a left
// run, then a right run, pulses start and waits for merge_done. Option: SENTINEL_PAD_EN.
module merge_run_feeder #(
    parameter int INPUT_ARR_LEN = 2,
    parameter int VAR_LEN       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic [7:0] i_src_data,
    input  logic       i_src_empty,
    output logic       o_src_rd,
    output logic [7:0] o_fifo_l_data,
    output logic       o_fifo_l_wr,
    input  logic       i_fifo_l_full,
    output logic [7:0] o_fifo_r_data,
    output logic       o_fifo_r_wr,
    input  logic       i_fifo_r_full,
    input  logic       i_flush,
    output logic       o_start,
    input  logic       i_merge_done,
    output logic       o_busy,
    output logic [7:0] o_pair_count,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL_L     = 3'd1,
        S_FILL_R     = 3'd2,
        S_START      = 3'd3,
        S_WAIT_MERGE = 3'd4
    } state_t;

    localparam logic [VAR_LEN-1:0] LAST_CNT = VAR_LEN'(INPUT_ARR_LEN - 1);

    state_t             r_state;
    logic [VAR_LEN-1:0] r_cnt;
    logic [7:0]         r_pair_count;

    logic w_fill_l;
    logic w_fill_r;
    logic w_xfer_l;
    logic w_xfer_r;
    logic w_pad_l;
    logic w_pad_r;
    logic w_abort;
    logic w_wr_l;
    logic w_wr_r;
    logic w_last;

    // Strobes are forced low while reset is held, even before the state register clears.
    assign w_fill_l = (r_state == S_FILL_L) && !i_rst;
    assign w_fill_r = (r_state == S_FILL_R) && !i_rst;
    assign w_xfer_l = w_fill_l && !i_src_empty && !i_fifo_l_full;
    assign w_xfer_r = w_fill_r && !i_src_empty && !i_fifo_r_full;
    assign w_last   = (r_cnt == LAST_CNT);

`ifdef SENTINEL_PAD_EN
    // An empty source at the head of a fresh pair means nothing is left to merge.
    assign w_abort = w_fill_l && i_flush && i_src_empty && !i_fifo_l_full && (r_cnt == '0);
    assign w_pad_l = w_fill_l && i_flush && i_src_empty && !i_fifo_l_full && (r_cnt != '0);
    assign w_pad_r = w_fill_r && i_flush && i_src_empty && !i_fifo_r_full;
`else
    logic w_unused_flush;
    assign w_unused_flush = i_flush;
    assign w_abort        = 1'b0;
    assign w_pad_l        = 1'b0;
    assign w_pad_r        = 1'b0;
`endif

    assign w_wr_l = w_xfer_l || w_pad_l;
    assign w_wr_r = w_xfer_r || w_pad_r;

    assign o_src_rd      = w_xfer_l || w_xfer_r;
    assign o_fifo_l_wr   = w_wr_l;
    assign o_fifo_r_wr   = w_wr_r;
    assign o_fifo_l_data = w_fill_l ? (w_pad_l ? 8'hFF : i_src_data) : 8'h00;
    assign o_fifo_r_data = w_fill_r ? (w_pad_r ? 8'hFF : i_src_data) : 8'h00;
    assign o_start       = (r_state == S_START) && !i_rst;
    assign o_busy        = (r_state != S_IDLE) && !i_rst;
    assign o_pair_count  = r_pair_count;
    assign o_state       = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pair_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_state <= S_FILL_L;
                        r_cnt   <= '0;
                    end
                end
                S_FILL_L: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_wr_l) begin
                        if (w_last) begin
                            r_state <= S_FILL_R;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + VAR_LEN'(1);
                        end
                    end
                end
                S_FILL_R: begin
                    if (w_wr_r) begin
                        if (w_last) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + VAR_LEN'(1);
                        end
                    end
                end
                S_START: begin
                    r_pair_count <= r_pair_count + 8'd1;
                    r_state      <= S_WAIT_MERGE;
                end
                S_WAIT_MERGE: begin
                    if (i_merge_done) begin
                        r_state <= i_go ? S_FILL_L : S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_run_feeder.sv
// Directed bench for merge_run_feeder: FWFT source model, write loggers and
// expected-byte queues for both runs.
module tb_merge_run_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [7:0] src_data;
  logic       src_empty;
  logic       src_rd;
  logic [7:0] l_data;
  logic       l_wr;
  logic       l_full;
  logic [7:0] r_data;
  logic       r_wr;
  logic       r_full;
  logic       flush;
  logic       start;
  logic       merge_done;
  logic       busy;
  logic [7:0] pair_count;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] src_q[$];
  logic [7:0] l_log[$];
  logic [7:0] r_log[$];
  logic [7:0] exp_l_q[$];
  logic [7:0] exp_r_q[$];

  int  cyc = 0;
  int  pops = 0;
  int  start_cnt = 0;
  int  start_cyc = 0;
  int  busy_cyc = 0;
  int  both_wr = 0;
  bit  busy_prev = 1'b0;
  bit  pop_pend = 1'b0;

  merge_run_feeder #(.INPUT_ARR_LEN(2), .VAR_LEN(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go),
    .i_src_data(src_data), .i_src_empty(src_empty), .o_src_rd(src_rd),
    .o_fifo_l_data(l_data), .o_fifo_l_wr(l_wr), .i_fifo_l_full(l_full),
    .o_fifo_r_data(r_data), .o_fifo_r_wr(r_wr), .i_fifo_r_full(r_full),
    .i_flush(flush), .o_start(start), .i_merge_done(merge_done),
    .o_busy(busy), .o_pair_count(pair_count), .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic refresh_src();
    src_empty = (src_q.size() == 0);
    src_data  = (src_q.size() == 0) ? 8'h00 : src_q[0];
  endtask

  // sample strobes mid-cycle; commit the source pop just after the edge
  always @(negedge clk) begin
    cyc++;
    if (l_wr) l_log.push_back(l_data);
    if (r_wr) r_log.push_back(r_data);
    if (l_wr && r_wr) both_wr++;
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (busy && !busy_prev) busy_cyc = cyc;
    busy_prev = busy;
    pop_pend = src_rd;
    if (src_rd) pops++;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend && src_q.size() > 0) void'(src_q.pop_front());
    pop_pend = 1'b0;
    refresh_src();
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_src(input logic [7:0] b);
    src_q.push_back(b);
    refresh_src();
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int  base = start_cnt;
    bit  seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (start_cnt != base) seen = 1'b1;
    end
    check_eq({tag, "_start"}, start_cnt - base, 1);
  endtask

  task automatic merge_pulse(input logic go_val);
    go = go_val;
    merge_done = 1'b1;
    step();
    merge_done = 1'b0;
  endtask

  // scoreboard: drain logged writes against expected queues
  task automatic check_logs(input string tag);
    logic [31:0] got;
    check_eq({tag, "_l_n"}, l_log.size(), exp_l_q.size());
    check_eq({tag, "_r_n"}, r_log.size(), exp_r_q.size());
    while (exp_l_q.size() > 0) begin
      got = (l_log.size() > 0) ? {24'h0, l_log.pop_front()} : 32'hFFFF_FFFF;
      check_eq({tag, "_l"}, got, {24'h0, exp_l_q.pop_front()});
    end
    while (exp_r_q.size() > 0) begin
      got = (r_log.size() > 0) ? {24'h0, r_log.pop_front()} : 32'hFFFF_FFFF;
      check_eq({tag, "_r"}, got, {24'h0, exp_r_q.pop_front()});
    end
    l_log.delete();
    r_log.delete();
  endtask

  initial begin
    int p0;
    int b0;
    rst = 1'b1; go = 1'b0; l_full = 1'b0; r_full = 1'b0;
    flush = 1'b0; merge_done = 1'b0;
    refresh_src();
    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pairs", pair_count, 0);
    check_eq("rst_state", state, 0);
    rst = 1'b0;
    step();

    // basic pair
    push_src(8'h05); push_src(8'h01); push_src(8'h07); push_src(8'h03);
    go = 1'b1;
    p0 = pops;
    wait_start("basic");
    exp_l_q = '{8'h05, 8'h01};
    exp_r_q = '{8'h07, 8'h03};
    check_logs("basic");
    check_eq("basic_pops", pops - p0, 4);
    check_eq("basic_start_cyc", start_cyc - busy_cyc, 4);
    check_eq("basic_pairs", pair_count, 1);
    check_eq("basic_wait", state, 4);
    merge_pulse(1'b0);
    check_eq("basic_idle", busy, 0);

    // left backpressure for three FILL_L cycles; go dropped mid-pair
    l_full = 1'b1;
    push_src(8'h0A); push_src(8'h0B); push_src(8'h0C); push_src(8'h0D);
    go = 1'b1;
    p0 = pops;
    repeat (4) step();
    check_eq("bp_pops", pops - p0, 0);
    check_eq("bp_l_n", l_log.size(), 0);
    check_eq("bp_state", state, 1);
    l_full = 1'b0;
    go = 1'b0;
    wait_start("bp");
    exp_l_q = '{8'h0A, 8'h0B};
    exp_r_q = '{8'h0C, 8'h0D};
    check_logs("bp");
    check_eq("bp_pops_total", pops - p0, 4);
    check_eq("bp_pairs", pair_count, 2);
    merge_pulse(1'b0);
    check_eq("bp_idle", busy, 0);

    // source starvation between bytes 2 and 3
    push_src(8'h11); push_src(8'h22);
    go = 1'b1;
    b0 = start_cnt;
    repeat (6) step();
    check_eq("starve_state", state, 2);
    check_eq("starve_r_n", r_log.size(), 0);
    check_eq("starve_no_start", start_cnt - b0, 0);
    push_src(8'h33); push_src(8'h44);
    wait_start("starve");
    exp_l_q = '{8'h11, 8'h22};
    exp_r_q = '{8'h33, 8'h44};
    check_logs("starve");
    check_eq("starve_pairs", pair_count, 3);

    // back-to-back with go held; stray merge_done in FILL_L
    repeat (3) step();
    merge_pulse(1'b1);
    check_eq("b2b_refill", state, 1);
    merge_pulse(1'b1);
    check_eq("b2b_ignore_done", state, 1);
    push_src(8'h55); push_src(8'h66); push_src(8'h77); push_src(8'h88);
    wait_start("b2b");
    exp_l_q = '{8'h55, 8'h66};
    exp_r_q = '{8'h77, 8'h88};
    check_logs("b2b");
    check_eq("b2b_pairs", pair_count, 4);

    // reset after the first left write
    merge_pulse(1'b1);
    push_src(8'hA1); push_src(8'hA2); push_src(8'hA3); push_src(8'hA4);
    for (int i = 0; i < 20 && l_log.size() == 0; i++) step();
    check_eq("mid_first_l", l_log.size(), 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_lwr", l_wr, 0);
    check_eq("mid_rst_srcrd", src_rd, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ldata", l_data, 0);
    step();
    check_eq("mid_rst_pairs", pair_count, 0);
    check_eq("mid_rst_state", state, 0);
    rst = 1'b0;
    push_src(8'hA5);
    wait_start("mid");
    exp_l_q = '{8'hA1, 8'hA2, 8'hA3};
    exp_r_q = '{8'hA4, 8'hA5};
    check_logs("mid");
    check_eq("mid_pairs", pair_count, 1);
    check_eq("pops_total", pops, 4 * start_cnt + 1);

`ifdef SENTINEL_PAD_EN
    merge_pulse(1'b0);
    flush = 1'b1;
    push_src(8'h10); push_src(8'h20); push_src(8'h30);
    go = 1'b1;
    p0 = pops;
    wait_start("pad");
    exp_l_q = '{8'h10, 8'h20};
    exp_r_q = '{8'h30, 8'hFF};
    check_logs("pad");
    check_eq("pad_pops", pops - p0, 3);
    merge_pulse(1'b1);
    check_eq("pad_refill", state, 1);
    go = 1'b0;
    b0 = start_cnt;
    step();
    check_eq("pad_abort_idle", busy, 0);
    repeat (3) step();
    check_eq("pad_no_start", start_cnt - b0, 0);
    flush = 1'b0;
`endif

    check_eq("no_dual_write", both_wr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
